// File: rtl/prog_run_sequencer.sv
// Start/done sequencer for the single-cycle core: clears the core, loads the entry PC,
// runs until halt (or watchdog expiry), drains in-flight writes and holds done until the next start.
module prog_run_sequencer #(
   parameter int unsigned PC_W      = 10,
   parameter int unsigned START0    = 0,
   parameter int unsigned START1    = 256,
   parameter int unsigned START2    = 512,
   parameter int unsigned DRAIN_CYC = 2,
   parameter int unsigned MAX_CYC   = 50000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic [1:0]      prog_sel,
   input  logic            halt,
   output logic            core_clr,
   output logic            pc_load,
   output logic [PC_W-1:0] pc_init,
   output logic            core_en,
   output logic            busy,
   output logic            done,
   output logic            timeout,
   output logic            bad_sel,
   output logic [31:0]     run_cycles
);

   typedef enum logic [2:0] {
      IDLE,
      CLEAR,
      RUN,
      DRAIN,
      DONE
   } state_t;

   state_t            state_q;
   logic [2:0]        drainCnt_q;
   logic [PC_W-1:0]   entryPc_d;
   logic [31:0]       runCycles_d;

   // Entry address for the selected program; selection 3 never reaches CLEAR.
   always_comb begin
      entryPc_d = PC_W'(START0);
      case (prog_sel)
         2'd1:    entryPc_d = PC_W'(START1);
         2'd2:    entryPc_d = PC_W'(START2);
         default: entryPc_d = PC_W'(START0);
      endcase
   end

   // Saturating run counter increment; the count includes the cycle being retired.
   always_comb begin
      runCycles_d = (run_cycles == 32'hFFFF_FFFF) ? run_cycles : run_cycles + 32'd1;
   end

   // Single sequencer FSM; every output is a register so start/halt never reach outputs combinationally.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         drainCnt_q <= 3'd0;
         core_clr   <= 1'b0;
         pc_load    <= 1'b0;
         pc_init    <= '0;
         core_en    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         timeout    <= 1'b0;
         bad_sel    <= 1'b0;
         run_cycles <= 32'd0;
      end else begin
         core_clr <= 1'b0;
         pc_load  <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  timeout    <= 1'b0;
                  run_cycles <= 32'd0;
                  if (prog_sel == 2'd3) begin
                     state_q <= DONE;
                     done    <= 1'b1;
                     bad_sel <= 1'b1;
                     busy    <= 1'b0;
                  end else begin
                     state_q  <= CLEAR;
                     done     <= 1'b0;
                     bad_sel  <= 1'b0;
                     busy     <= 1'b1;
                     core_clr <= 1'b1;
                     pc_load  <= 1'b1;
                     pc_init  <= entryPc_d;
                  end
               end
            end
            CLEAR: begin
               state_q <= RUN;
               core_en <= 1'b1;
            end
            RUN: begin
               run_cycles <= runCycles_d;
               // A halt in the final watchdog cycle still counts as a normal finish.
               if (halt) begin
                  state_q    <= DRAIN;
                  core_en    <= 1'b0;
                  drainCnt_q <= 3'(DRAIN_CYC - 1);
               end else if (runCycles_d >= 32'(MAX_CYC)) begin
                  state_q <= DONE;
                  core_en <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  timeout <= 1'b1;
               end
            end
            DRAIN: begin
               if (drainCnt_q == 3'd0) begin
                  state_q <= DONE;
                  busy    <= 1'b0;
                  done    <= 1'b1;
               end else begin
                  drainCnt_q <= drainCnt_q - 3'd1;
               end
            end
            default: begin
               state_q <= IDLE;
               core_en <= 1'b0;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
